// File: rtl/uart_rx_monitor_if.sv
// Receiver-side signal bundle for uart_rx_monitor: serial line in, decoded byte and status out.
// The slave modport is the receiver; the master modport is whoever drives the line and reads results.
interface uart_rx_monitor_if;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned COUNT_W = 16;

    logic               rx;
    logic [DATA_W-1:0]  data_o;
    logic               valid_o;
    logic               frame_err_o;
    logic               busy_o;
    logic [COUNT_W-1:0] byte_count_o;

    modport master (
        output rx,
        input  data_o,
        input  valid_o,
        input  frame_err_o,
        input  busy_o,
        input  byte_count_o
    );

    modport slave (
        input  rx,
        output data_o,
        output valid_o,
        output frame_err_o,
        output busy_o,
        output byte_count_o
    );
endinterface

// File: rtl/uart_rx_monitor.sv
// 8N1 serial receiver watching the SoC uart_tx pin; reports bytes, a good-byte count and framing errors.
// Mid-bit sampling timed from the synchronized falling edge of the start bit.
module uart_rx_monitor #(
    parameter int unsigned CLK_HZ = 10000000,
    parameter int unsigned BAUD   = 9600
) (
    input  logic               clk,
    input  logic               reset,
    uart_rx_monitor_if.slave   bus
);
    localparam int unsigned DIV     = CLK_HZ / BAUD;
    localparam int unsigned HALF    = DIV / 2;
    localparam int unsigned CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned COUNT_W = 16;
    localparam int unsigned IDX_W   = 3;

    localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_e;

    state_e             state_q;
    logic               rx_m_q;
    logic               rx_s_q;
    logic               rx_p_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   bit_idx_q;
    logic [DATA_W-1:0]  shift_q;
    logic [DATA_W-1:0]  data_q;
    logic               valid_q;
    logic               frame_err_q;
    logic               busy_q;
    logic [COUNT_W-1:0] byte_count_q;

    logic               start_edge_c;
    logic               cnt_zero_c;
    logic [CNT_W-1:0]   cnt_d;
    logic [DATA_W-1:0]  shift_d;
    logic [COUNT_W-1:0] byte_count_d;
    logic [IDX_W-1:0]   bit_idx_d;

    // Synchronizer and history reset low, so a line held low through reset never looks like a start.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_m_q <= 1'b0;
            rx_s_q <= 1'b0;
            rx_p_q <= 1'b0;
        end else begin
            rx_m_q <= bus.rx;
            rx_s_q <= rx_m_q;
            rx_p_q <= rx_s_q;
        end
    end

    assign start_edge_c = rx_p_q & ~rx_s_q;
    assign cnt_zero_c   = (cnt_q == '0);
    assign cnt_d        = cnt_q - CNT_W'(1);
    assign shift_d      = {rx_s_q, shift_q[DATA_W-1:1]};
    assign byte_count_d = byte_count_q + COUNT_W'(1);
    assign bit_idx_d    = bit_idx_q + IDX_W'(1);

    // Frame FSM; status pulses default low every cycle so each lasts exactly one clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
            byte_count_q <= '0;
        end else begin
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start_edge_c) begin
                        cnt_q   <= HALF_M1;
                        state_q <= ST_START;
                        busy_q  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (!cnt_zero_c) begin
                        cnt_q <= cnt_d;
                    end else if (rx_s_q) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q     <= DIV_M1;
                        bit_idx_q <= '0;
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (!cnt_zero_c) begin
                        cnt_q <= cnt_d;
                    end else begin
                        shift_q <= shift_d;
                        cnt_q   <= DIV_M1;
                        if (bit_idx_q == LAST_BIT) begin
                            state_q <= ST_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_d;
                        end
                    end
                end
                ST_STOP: begin
                    if (!cnt_zero_c) begin
                        cnt_q <= cnt_d;
                    end else if (rx_s_q) begin
                        // Leaving at mid-stop leaves half a bit to catch a back-to-back start.
                        data_q       <= shift_q;
                        valid_q      <= 1'b1;
                        byte_count_q <= byte_count_d;
                        state_q      <= ST_IDLE;
                        busy_q       <= 1'b0;
                    end else begin
                        frame_err_q <= 1'b1;
                        state_q     <= ST_BREAK;
                    end
                end
                ST_BREAK: begin
                    if (rx_s_q) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_o       = data_q;
    assign bus.valid_o      = valid_q;
    assign bus.frame_err_o  = frame_err_q;
    assign bus.busy_o       = busy_q;
    assign bus.byte_count_o = byte_count_q;
endmodule
